// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of a sync FIFO, with bounded burst locking per owner.
// Optional per-requester push and stall counters are enabled with FIFO_ARB_PERF_EN.
module fifo_push_arbiter #(
  parameter int NumReq    = 3,
  parameter int DataWidth = 8,
  parameter int MaxBurst  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*DataWidth-1:0]   data_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic                          fifo_we_o,
  output logic [DataWidth-1:0]          fifo_wdata_o,
  input  logic                          fifo_full_i
`ifdef FIFO_ARB_PERF_EN
  ,
  output logic [NumReq*16-1:0]          perf_push_cnt_o,
  output logic [15:0]                   perf_stall_cnt_o
`endif
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [PtrW-1:0] LastIdx     = PtrW'(NumReq - 1);
  localparam logic [CntW-1:0] MaxBurstCnt = CntW'(MaxBurst);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_r;
  logic [PtrW-1:0]     rr_ptr_r;
  logic [PtrW-1:0]     owner_r;
  logic [CntW-1:0]     burst_cnt_r;

  logic                win_vld_s;
  logic [PtrW-1:0]     win_idx_s;
  logic                accept_s;
  logic [CntW-1:0]     next_cnt_s;

  // Modulo-NumReq pointer increment; the pointer never reaches NumReq.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == LastIdx) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  // Winner selection: a live lock wins outright, otherwise scan from rr_ptr.
  always_comb begin
    logic [PtrW-1:0] scan_s;
    win_vld_s = 1'b0;
    win_idx_s = {PtrW{1'b0}};
    scan_s    = rr_ptr_r;
    if ((state_r == LOCKED) && req_i[owner_r]) begin
      win_vld_s = 1'b1;
      win_idx_s = owner_r;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (!win_vld_s && req_i[scan_s]) begin
          win_vld_s = 1'b1;
          win_idx_s = scan_s;
        end else begin
          win_vld_s = win_vld_s;
        end
        scan_s = ptr_inc(scan_s);
      end
    end
  end

  assign accept_s  = rst && win_vld_s && !fifo_full_i;
  assign fifo_we_o = accept_s;

  // Burst count restarts whenever the accepted winner is not the current lock holder.
  always_comb begin
    next_cnt_s = CntW'(1);
    if ((state_r == LOCKED) && (win_idx_s == owner_r)) begin
      next_cnt_s = burst_cnt_r + CntW'(1);
    end else begin
      next_cnt_s = CntW'(1);
    end
  end

  // Zero-latency grant and write data toward the FIFO.
  always_comb begin
    gnt_o        = {NumReq{1'b0}};
    fifo_wdata_o = {DataWidth{1'b0}};
    if (accept_s) begin
      gnt_o[win_idx_s] = 1'b1;
      fifo_wdata_o     = data_i[int'(win_idx_s)*DataWidth +: DataWidth];
    end else begin
      gnt_o        = {NumReq{1'b0}};
      fifo_wdata_o = {DataWidth{1'b0}};
    end
  end

  // Lock/round-robin state; a full FIFO freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {PtrW{1'b0}};
      owner_r     <= {PtrW{1'b0}};
      burst_cnt_r <= {CntW{1'b0}};
    end else if (accept_s) begin
      if (next_cnt_s < MaxBurstCnt) begin
        state_r     <= LOCKED;
        owner_r     <= win_idx_s;
        burst_cnt_r <= next_cnt_s;
      end else begin
        state_r     <= IDLE;
        burst_cnt_r <= {CntW{1'b0}};
        rr_ptr_r    <= ptr_inc(win_idx_s);
      end
    end else if (!fifo_full_i && (state_r == LOCKED) && !req_i[owner_r]) begin
      state_r     <= IDLE;
      burst_cnt_r <= {CntW{1'b0}};
      rr_ptr_r    <= ptr_inc(owner_r);
    end else begin
      state_r     <= state_r;
      burst_cnt_r <= burst_cnt_r;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

`ifdef FIFO_ARB_PERF_EN
  logic [15:0] push_cnt_r [NumReq];
  logic [15:0] stall_cnt_r;

  // Free-running wrap-around counters for pushes per requester and full stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NumReq; k++) begin
        push_cnt_r[k] <= 16'd0;
      end
      stall_cnt_r <= 16'd0;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        if (gnt_o[k]) begin
          push_cnt_r[k] <= push_cnt_r[k] + 16'd1;
        end else begin
          push_cnt_r[k] <= push_cnt_r[k];
        end
      end
      if ((|req_i) && fifo_full_i) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  // Pack the per-requester counters onto the flat output.
  always_comb begin
    perf_push_cnt_o = {(NumReq*16){1'b0}};
    for (int k = 0; k < NumReq; k++) begin
      perf_push_cnt_o[k*16 +: 16] = push_cnt_r[k];
    end
  end

  assign perf_stall_cnt_o = stall_cnt_r;
`endif

endmodule
